mdu_hilo: RTL
=============

// Module: mdu_hilo
// PURPOSE
//  Multi-cycle multiply/divide unit with its own HI/LO register pair. Replaces the
//  single-cycle ALU multiply and separate hilo_reg in the EX stage. It adds a WIDTH-cycle
//  radix-2 divider, a configurable-latency multiplier and a pipeline stall/cancel handshake.
//  The hazard unit holds F/D/E while busy is high and drives cancel on an EX-stage flush.
// PARAMETERS
//  WIDTH    32  operand width; hi/lo are each WIDTH bits
//  MUL_LAT  2   multiply latency in clock edges, 1..8
// PORTS
//  clk     in   1      clock; all state changes on the rising edge
//  rst     in   1      synchronous, active-low reset
//  start   in   1      one-cycle request; sampled only when busy=0
//  op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  srca    in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//  srcb    in   WIDTH  multiplier / divisor
//  cancel  in   1      abort the in-flight op (EX flush)
//  busy    out  1      op in progress; hazard unit stalls on it
//  done    out  1      one-cycle pulse: hi/lo now hold the new result
//  hi      out  WIDTH  HI register (registered output)
//  lo      out  WIDTH  LO register (registered output)
// BEHAVIOUR
//  - Reset (rst=0 at an edge): hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.
//    Reset applies in any state, including mid-operation.
//  - Edge E0 is the edge at which start=1 is accepted. Cycle k is the cycle after edge Ek.
//  - States: IDLE, MUL, DIV.
//    IDLE->MUL on MULT/MULTU; IDLE->DIV on DIV/DIVU; MUL/DIV->IDLE on completion or cancel.
//  - MTHI/MTLO: stay in IDLE; hi (or lo) <= srca at E0. The other register is unchanged.
//    busy and done stay 0.
//  - MULT/MULTU: operands latched at E0. busy=1 in cycles 0..MUL_LAT-1.
//    {hi,lo} <= full 2*WIDTH product at edge E(MUL_LAT); done=1 in cycle MUL_LAT.
//    MULT is signed x signed; MULTU is unsigned x unsigned.
//  - DIV/DIVU: restoring radix-2 algorithm.
//    E0: latch |dividend| and |divisor| (raw values for DIVU), plus the sign flags.
//    E1..E(WIDTH): one quotient bit per edge, MSB first.
//    E(WIDTH+1): sign fix-up and write to hi/lo.
//    busy=1 in cycles 0..WIDTH; done=1 in cycle WIDTH+1.
//    lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
//    Quotient is negated iff the operand signs differ (DIV only).
//  - Divide by zero (either signedness): full latency; lo = all ones, hi = dividend.
//  - DIV of -2^(WIDTH-1) by -1: lo = -2^(WIDTH-1), hi = 0; no trap.
//  - start while busy=1: ignored, no state change. Upstream must hold the instruction.
//  - cancel=1 while busy: return to IDLE at that edge; hi/lo unchanged; no done pulse.
//    busy=0 in the next cycle and a new start is accepted there.
//  - cancel and start in the same cycle while idle: cancel wins and start is ignored.
//  - done and busy are never both 1. done falls after exactly one cycle.
//  - Back-to-back: start may be accepted in the cycle where done=1. That op sees the
//    updated hi/lo.
//  - Undefined op codes with start=1: no effect.
// TESTING
//  (WIDTH=32, MUL_LAT=2)
//  1. MULT 0xFFFFFFFF*0x00000002 -> busy cycles 0-1; done cycle 2; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     Same operands, MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
//  2. DIV 0xFFFFFFF9 (-7) / 0x00000002 -> busy cycles 0-32; done cycle 33;
//     lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
//  3. DIVU 0x80000000/0 -> lo=0xFFFFFFFF, hi=0x80000000.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. Start DIV, cancel=1 in cycle 10 -> no done; hi/lo keep prior values; busy=0 in cycle 11.
//     MULTU 3*5 started in cycle 11 -> lo=15, hi=0.
//  5. MTHI 0x12345678 while idle -> hi=0x12345678 next cycle, lo unchanged.
//     MTLO issued while a DIV is busy -> ignored.
//  6. rst=0 in cycle 20 of a DIV -> next cycle hi=lo=0, busy=done=0.
//     No done pulse after rst is released.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with its own HI/LO register pair.
// Multiplies take MUL_LAT edges after acceptance. Divides take WIDTH+1 edges
// after acceptance: WIDTH restoring radix-2 steps, then one sign fix-up edge.
// busy stalls the pipeline. cancel aborts an op in flight without touching hi/lo.
module mdu_hilo #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // The counter counts multiply edges or divide steps, whichever is larger.
    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [WIDTH-1:0]  hi_reg;
    logic [WIDTH-1:0]  lo_reg;

    // Shared operand registers. For a multiply they hold the multiplicand and
    // the multiplier. For a divide, opa_reg is the dividend shifter that turns
    // into the quotient, and opb_reg holds |divisor|.
    logic [WIDTH-1:0]  opa_reg;
    logic [WIDTH-1:0]  opb_reg;
    logic [WIDTH-1:0]  rem_reg;
    logic [WIDTH-1:0]  raw_dvd_reg;   // unmodified dividend, returned on divide by zero
    logic              mul_signed_reg;
    logic              div_zero_reg;
    logic              neg_quo_reg;
    logic              neg_rem_reg;

    // Absolute values of the incoming operands, used only by signed DIV.
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;

    assign a_neg = (op == OP_DIV) && srca[WIDTH-1];
    assign b_neg = (op == OP_DIV) && srcb[WIDTH-1];
    assign abs_a = a_neg ? (~srca + 1'b1) : srca;
    assign abs_b = b_neg ? (~srcb + 1'b1) : srcb;

    // Full-width product. Sign- or zero-extending both operands to 2*WIDTH
    // gives the correct low 2*WIDTH bits for both MULT and MULTU.
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;

    assign ext_a   = {{WIDTH{mul_signed_reg & opa_reg[WIDTH-1]}}, opa_reg};
    assign ext_b   = {{WIDTH{mul_signed_reg & opb_reg[WIDTH-1]}}, opb_reg};
    assign product = ext_a * ext_b;

    // One restoring-division step. The partial remainder is always below the
    // divisor, so a successful trial fits back into WIDTH bits.
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;
    logic              trial_ok;

    assign shifted  = {rem_reg, opa_reg[WIDTH-1]};
    assign trial    = shifted - {1'b0, opb_reg};
    assign trial_ok = ~trial[WIDTH];

    // Sign fix-up applied on the final divide edge.
    logic [WIDTH-1:0]  quo_fixed;
    logic [WIDTH-1:0]  rem_fixed;

    assign quo_fixed = neg_quo_reg ? (~opa_reg + 1'b1) : opa_reg;
    assign rem_fixed = neg_rem_reg ? (~rem_reg + 1'b1) : rem_reg;

    // Control FSM and datapath. done is a one-edge pulse that is cleared by default.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            rem_reg        <= '0;
            raw_dvd_reg    <= '0;
            mul_signed_reg <= 1'b0;
            div_zero_reg   <= 1'b0;
            neg_quo_reg    <= 1'b0;
            neg_rem_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // If cancel arrives together with start, cancel wins.
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                opa_reg        <= srca;
                                opb_reg        <= srcb;
                                mul_signed_reg <= (op == OP_MULT);
                                cnt_reg        <= '0;
                                busy_reg       <= 1'b1;
                                state_reg      <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                opa_reg      <= abs_a;
                                opb_reg      <= abs_b;
                                rem_reg      <= '0;
                                raw_dvd_reg  <= srca;
                                div_zero_reg <= (srcb == '0);
                                neg_quo_reg  <= a_neg ^ b_neg;
                                neg_rem_reg  <= a_neg;
                                cnt_reg      <= '0;
                                busy_reg     <= 1'b1;
                                state_reg    <= DIV;
                            end
                            OP_MTHI: hi_reg <= srca;
                            OP_MTLO: lo_reg <= srca;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cancel) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == MUL_LAST) begin
                        hi_reg    <= product[2*WIDTH-1:WIDTH];
                        lo_reg    <= product[WIDTH-1:0];
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DIV: begin
                    if (cancel) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == DIV_LAST) begin
                        // Divide by zero runs the full latency, then reports
                        // an all-ones quotient and the original dividend.
                        if (div_zero_reg) begin
                            lo_reg <= '1;
                            hi_reg <= raw_dvd_reg;
                        end else begin
                            lo_reg <= quo_fixed;
                            hi_reg <= rem_fixed;
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        opa_reg <= {opa_reg[WIDTH-2:0], trial_ok};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
